// File: rtl/keypad_scanner_pkg.sv
// Shared constants, row-slot state type and key index helper for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = 16;

  localparam logic [KEYS-1:0] KEY_IDLE = 16'hffff;

  // One state per driven row; the state value is the row number.
  typedef enum logic [1:0] {
    SLOT_ROW0 = 2'd0,
    SLOT_ROW1 = 2'd1,
    SLOT_ROW2 = 2'd2,
    SLOT_ROW3 = 2'd3
  } slot_e;

  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  // frame_done and key_valid are single-cycle pulses with no ready: the consumer must
  // accept them on the cycle they are high; key_state and key_code hold between pulses.
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [KEYS-1:0] key_state;
  logic            frame_done;
  logic            key_valid;
  logic [3:0]      key_code;
  slot_e           slot_dbg;

  modport master (
    input  col_n,
    output row_n, key_state, frame_done, key_valid, key_code, slot_dbg
  );

  modport slave (
    output col_n,
    input  row_n, key_state, frame_done, key_valid, key_code, slot_dbg
  );

endinterface

// File: rtl/keypad_scanner_prio_enc.sv
// Combinational lowest-set-bit encoder over the 16-key vector.
module key_prio_enc
  import keypad_pkg::*;
(
  input  logic [KEYS-1:0] vec,
  output logic [3:0]      idx,
  output logic            any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one low row per slot, samples the synchronised
// columns mid-slot and publishes an active-low key bitmap once per four-slot frame.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 49_999,
  parameter int SAMPLE_AT = 25_000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int CNT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV + 1);

  logic [CNT_W-1:0] cnt_q;
  slot_e            slot_q, slot_d;
  logic [COLS-1:0]  col_sync_q1, col_sync_q2;
  logic [ROWS-1:0]  row_n_q;
  logic [KEYS-1:0]  shadow_q, key_state_q;
  logic             frame_done_q, key_valid_q;
  logic [3:0]       key_code_q;

  logic             cnt_wrap, sample_now, frame_end;
  logic [KEYS-1:0]  newly;
  logic [3:0]       newly_idx;
  logic             newly_any;

  assign cnt_wrap   = (cnt_q == CNT_W'(SCAN_DIV));
  assign sample_now = (cnt_q == CNT_W'(SAMPLE_AT));
  assign frame_end  = cnt_wrap && (slot_q == SLOT_ROW3);

  // Released last frame (1) and pressed now (0).
  assign newly = key_state_q & ~shadow_q;

  key_prio_enc u_prio (
    .vec (newly),
    .idx (newly_idx),
    .any (newly_any)
  );

  always_ff @(posedge clk) begin
    if (rst) slot_q <= SLOT_ROW0;
    else     slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    if (cnt_wrap) begin
      case (slot_q)
        SLOT_ROW0: slot_d = SLOT_ROW1;
        SLOT_ROW1: slot_d = SLOT_ROW2;
        SLOT_ROW2: slot_d = SLOT_ROW3;
        SLOT_ROW3: slot_d = SLOT_ROW0;
        default:   slot_d = SLOT_ROW0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_sync_q1  <= 4'hf;
      col_sync_q2  <= 4'hf;
      cnt_q        <= '0;
      row_n_q      <= 4'hf;
      shadow_q     <= KEY_IDLE;
      key_state_q  <= KEY_IDLE;
      frame_done_q <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      col_sync_q1  <= kp.col_n;
      col_sync_q2  <= col_sync_q1;
      cnt_q        <= cnt_wrap ? '0 : cnt_q + 1'b1;
      // Row drive follows the slot that is current after this edge.
      row_n_q      <= ~(4'b0001 << slot_d);
      if (sample_now) begin
        shadow_q[key_index(slot_q, 2'd0) +: COLS] <= col_sync_q2;
      end
      frame_done_q <= frame_end;
      key_valid_q  <= frame_end && newly_any;
      if (frame_end) begin
        key_state_q <= shadow_q;
        if (newly_any) key_code_q <= newly_idx;
      end
    end
  end

  assign kp.row_n      = row_n_q;
  assign kp.key_state  = key_state_q;
  assign kp.frame_done = frame_done_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_code   = key_code_q;
  assign kp.slot_dbg   = slot_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with an 8-cycle slot and a 32-cycle frame.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'h0000;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          elapsed;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(7), .SAMPLE_AT(4)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kp.col_n = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp.row_n[r] && pressed[r*4+c]) kp.col_n[c] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advances edge by edge until frame_done is seen or the budget runs out.
  task automatic wait_frame(input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!kp.frame_done && n < budget);
  endtask

  task automatic chk_frame(input string tag, input int exp_edges, input logic [15:0] exp_state,
                           input logic exp_valid, input logic [3:0] exp_code);
    wait_frame(80, elapsed);
    chk({tag, "_edges"}, 16'(elapsed), 16'(exp_edges));
    chk({tag, "_done"},  16'(kp.frame_done), 16'd1);
    chk({tag, "_state"}, kp.key_state, exp_state);
    chk({tag, "_valid"}, 16'(kp.key_valid), 16'(exp_valid));
    chk({tag, "_code"},  16'(kp.key_code), 16'(exp_code));
  endtask

  initial begin
    // Reset values, then release and the row walk.
    tick(3);
    chk("rst_row_n", 16'(kp.row_n), 16'h000f);
    chk("rst_state", kp.key_state, 16'hffff);
    chk("rst_done",  16'(kp.frame_done), 16'd0);
    chk("rst_valid", 16'(kp.key_valid), 16'd0);
    chk("rst_code",  16'(kp.key_code), 16'd0);
    rst = 1'b0;
    tick(1);
    chk("row_e1",  16'(kp.row_n), 16'h000e);
    tick(7);
    chk("row_e8",  16'(kp.row_n), 16'h000d);
    chk("slot_e8", 16'(kp.slot_dbg), 16'd1);
    tick(8);
    chk("row_e16", 16'(kp.row_n), 16'h000b);
    tick(8);
    chk("row_e24", 16'(kp.row_n), 16'h0007);
    tick(7);
    chk("done_e31", 16'(kp.frame_done), 16'd0);
    tick(1);
    chk("done_e32",  16'(kp.frame_done), 16'd1);
    chk("state_e32", kp.key_state, 16'hffff);
    chk("valid_e32", 16'(kp.key_valid), 16'd0);
    tick(1);
    chk("done_e33", 16'(kp.frame_done), 16'd0);
    chk("row_e33",  16'(kp.row_n), 16'h000e);

    // Key 6 held from reset.
    rst = 1'b1;
    pressed = 16'h0040;
    tick(2);
    rst = 1'b0;
    chk_frame("k6_f1", 32, 16'hffbf, 1'b1, 4'd6);
    chk_frame("k6_f2", 32, 16'hffbf, 1'b0, 4'd6);

    // Keys 3 and 9 pressed together; key 6 released.
    pressed = 16'h0208;
    chk_frame("k39_f1", 32, 16'hfdf7, 1'b1, 4'd3);
    chk_frame("k39_f2", 32, 16'hfdf7, 1'b0, 4'd3);

    // Release everything.
    pressed = 16'h0000;
    chk_frame("rel", 32, 16'hffff, 1'b0, 4'd3);

    // Key 1 pressed after row 0 has already been sampled.
    tick(10);
    pressed = 16'h0002;
    chk_frame("k1_late", 22, 16'hffff, 1'b0, 4'd3);
    chk_frame("k1_next", 32, 16'hfffd, 1'b1, 4'd1);

    // Mid-frame reset with key 6 held.
    pressed = 16'h0040;
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("mr_row_n", 16'(kp.row_n), 16'h000f);
    chk("mr_state", kp.key_state, 16'hffff);
    chk("mr_done",  16'(kp.frame_done), 16'd0);
    chk("mr_valid", 16'(kp.key_valid), 16'd0);
    chk("mr_code",  16'(kp.key_code), 16'd0);
    rst = 1'b0;
    chk_frame("mr_f1", 32, 16'hffbf, 1'b1, 4'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
